// File: rtl/imm_gen_pipe_if.sv
// Bus bundle for imm_gen_pipe: fetch-side handshake, flush and the result
// side handshake. XLEN must match the XLEN of the attached imm_gen_pipe.
interface imm_gen_pipe_if #(
  parameter int XLEN = 32
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_fmt;
  logic [5:0]      out_shamt;
  logic            out_illegal;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_target;

  // Instruction source / result consumer side
  modport master (
    output flush, in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_shamt, out_illegal,
           out_pc, out_target
  );

  // Immediate generator side
  modport slave (
    input  flush, in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_shamt, out_illegal,
           out_pc, out_target
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// Registered, self-decoding immediate generator for the decode stage.
// Decodes the immediate format from opcode/funct3, produces the
// sign-extended immediate, shift amount, illegal flag and PC-relative
// target, and buffers results in an output register plus one skid entry
// so that one instruction per cycle is sustained under back-pressure.
module imm_gen_pipe #(
  parameter int XLEN    = 32,
  parameter bit EN_ZIMM = 1'b1
) (
  input logic          clk,
  input logic          rst_n,
  imm_gen_pipe_if.slave bus
);

  typedef enum logic [2:0] {
    FMT_NONE  = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_SHAMT = 3'd6,
    FMT_Z     = 3'd7
  } fmt_e;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    fmt_e            fmt;
    logic [5:0]      shamt;
    logic            illegal;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] target;
  } result_t;

  result_t dec;
  result_t out_q;
  result_t skid_q;
  logic    out_valid_q;
  logic    skid_valid_q;
  logic    in_fire;

  logic [6:0]  op;
  logic [2:0]  f3;
  logic [31:0] inst;
  logic [31:0] u32;
  logic        wide_shift;
  logic        funct_ok;

  assign inst = bus.in_inst;
  assign op   = inst[6:0];
  assign f3   = inst[14:12];
  assign u32  = {inst[31:12], 12'b0};

  // Decode format, immediate, shift amount and target for the offered word
  always_comb begin
    dec        = '0;
    dec.fmt    = FMT_NONE;
    dec.pc     = bus.in_pc;
    wide_shift = 1'b0;
    funct_ok   = 1'b1;

    case (op)
      7'b0000011, 7'b1100111, 7'b0001111: dec.fmt = FMT_I;
      7'b0010011: dec.fmt = (f3 == 3'b001 || f3 == 3'b101) ? FMT_SHAMT : FMT_I;
      7'b0100011: dec.fmt = FMT_S;
      7'b1100011: dec.fmt = FMT_B;
      7'b0110111, 7'b0010111: dec.fmt = FMT_U;
      7'b1101111: dec.fmt = FMT_J;
      7'b0110011: dec.fmt = FMT_NONE;
      7'b1110011: dec.fmt = (f3[2] && EN_ZIMM) ? FMT_Z : FMT_I;
      7'b0011011: begin
        if (XLEN == 64)
          dec.fmt = (f3 == 3'b001 || f3 == 3'b101) ? FMT_SHAMT : FMT_I;
        else
          dec.illegal = 1'b1;
      end
      7'b0111011: begin
        if (XLEN != 64)
          dec.illegal = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase

    if (inst[1:0] != 2'b11)
      dec.illegal = 1'b1;

    // Only the RV64 full-width OP-IMM shifts use a 6-bit shamt; everywhere
    // else inst[25] belongs to funct7 and must be zero.
    if (dec.fmt == FMT_SHAMT) begin
      wide_shift = (XLEN == 64) && (op == 7'b0010011);
      if (wide_shift) begin
        dec.shamt = inst[25:20];
        funct_ok  = (inst[31:26] == 6'b000000) ||
                    (inst[31:26] == 6'b010000 && f3 == 3'b101);
      end else begin
        dec.shamt = {1'b0, inst[24:20]};
        funct_ok  = (inst[31:25] == 7'b0000000) ||
                    (inst[31:25] == 7'b0100000 && f3 == 3'b101);
      end
      if (!funct_ok)
        dec.illegal = 1'b1;
    end

    case (dec.fmt)
      FMT_I:     dec.imm = XLEN'(signed'(inst[31:20]));
      FMT_S:     dec.imm = XLEN'(signed'({inst[31:25], inst[11:7]}));
      FMT_B:     dec.imm = XLEN'(signed'({inst[31], inst[7], inst[30:25],
                                          inst[11:8], 1'b0}));
      FMT_U:     dec.imm = XLEN'(signed'(u32));
      FMT_J:     dec.imm = XLEN'(signed'({inst[31], inst[19:12], inst[20],
                                          inst[30:21], 1'b0}));
      FMT_SHAMT: dec.imm = XLEN'(dec.shamt);
      FMT_Z:     dec.imm = XLEN'(inst[19:15]);
      default:   dec.imm = '0;
    endcase

    if (dec.fmt == FMT_B || dec.fmt == FMT_J || op == 7'b0010111)
      dec.target = bus.in_pc + dec.imm;

    // An unsupported encoding reports nothing but the flag and the pc
    if (dec.illegal) begin
      dec.fmt    = FMT_NONE;
      dec.imm    = '0;
      dec.shamt  = '0;
      dec.target = '0;
    end
  end

  assign in_fire = bus.in_valid && !skid_valid_q;

  // Output register plus skid entry: flush wins, then refill output from
  // skid (FIFO order), otherwise park new results in skid when stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (bus.flush) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (!out_valid_q || bus.out_ready) begin
      if (skid_valid_q) begin
        out_q        <= skid_q;
        out_valid_q  <= 1'b1;
        skid_valid_q <= 1'b0;
      end else if (in_fire) begin
        out_q       <= dec;
        out_valid_q <= 1'b1;
      end else begin
        out_valid_q <= 1'b0;
      end
    end else if (in_fire) begin
      skid_q       <= dec;
      skid_valid_q <= 1'b1;
    end
  end

  assign bus.in_ready    = !skid_valid_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_imm     = out_q.imm;
  assign bus.out_fmt     = out_q.fmt;
  assign bus.out_shamt   = out_q.shamt;
  assign bus.out_illegal = out_q.illegal;
  assign bus.out_pc      = out_q.pc;
  assign bus.out_target  = out_q.target;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: one RV32 and one RV64 instance, decode
// vectors with hand-computed results, back-pressure, flush and async reset.
module tb_imm_gen_pipe;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  imm_gen_pipe_if #(.XLEN(32)) b32 ();
  imm_gen_pipe_if #(.XLEN(64)) b64 ();

  imm_gen_pipe #(.XLEN(32), .EN_ZIMM(1'b1)) dut32 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (b32.slave)
  );

  imm_gen_pipe #(.XLEN(64), .EN_ZIMM(1'b1)) dut64 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (b64.slave)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Offer one instruction, wait for acceptance, return at the negedge after it
  task automatic applyStimulus(input bit sel64, input logic [31:0] inst,
                               input logic [63:0] pc);
    int n = 0;
    @(negedge clk);
    if (sel64) begin
      b64.in_valid = 1'b1; b64.in_inst = inst; b64.in_pc = pc; b64.out_ready = 1'b1;
      while (!b64.in_ready && n < 10) begin @(negedge clk); n++; end
    end else begin
      b32.in_valid = 1'b1; b32.in_inst = inst; b32.in_pc = pc[31:0]; b32.out_ready = 1'b1;
      while (!b32.in_ready && n < 10) begin @(negedge clk); n++; end
    end
    if (n >= 10) checkOutput("accept_timeout", 64'd0, 64'd1);
    @(negedge clk);
    b32.in_valid = 1'b0;
    b64.in_valid = 1'b0;
  endtask

  task automatic runVector(input bit sel64, input string tag,
                           input logic [31:0] inst, input logic [63:0] pc,
                           input logic [63:0] e_imm, input logic [2:0] e_fmt,
                           input logic [5:0] e_sh, input logic e_ill,
                           input logic [63:0] e_tgt);
    applyStimulus(sel64, inst, pc);
    if (sel64) begin
      checkOutput({tag, ".valid"}, 64'(b64.out_valid), 64'd1);
      checkOutput({tag, ".imm"}, b64.out_imm, e_imm);
      checkOutput({tag, ".fmt"}, 64'(b64.out_fmt), 64'(e_fmt));
      checkOutput({tag, ".shamt"}, 64'(b64.out_shamt), 64'(e_sh));
      checkOutput({tag, ".illegal"}, 64'(b64.out_illegal), 64'(e_ill));
      checkOutput({tag, ".pc"}, b64.out_pc, pc);
      checkOutput({tag, ".target"}, b64.out_target, e_tgt);
    end else begin
      checkOutput({tag, ".valid"}, 64'(b32.out_valid), 64'd1);
      checkOutput({tag, ".imm"}, 64'(b32.out_imm), e_imm);
      checkOutput({tag, ".fmt"}, 64'(b32.out_fmt), 64'(e_fmt));
      checkOutput({tag, ".shamt"}, 64'(b32.out_shamt), 64'(e_sh));
      checkOutput({tag, ".illegal"}, 64'(b32.out_illegal), 64'(e_ill));
      checkOutput({tag, ".pc"}, 64'(b32.out_pc), 64'(pc[31:0]));
      checkOutput({tag, ".target"}, 64'(b32.out_target), e_tgt);
    end
  endtask

  // Count cycles in which the 32-bit instance shows a result
  task automatic countValid32(input int cycles, output int seen);
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (b32.out_valid) seen++;
    end
  endtask

  // Abort if the run stalls
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main directed sequence
  initial begin
    logic [31:0] rx_pc[$];
    int acc;
    int first_drop;
    int seen;

    b32.flush = 0; b32.in_valid = 0; b32.in_inst = '0; b32.in_pc = '0; b32.out_ready = 1;
    b64.flush = 0; b64.in_valid = 0; b64.in_inst = '0; b64.in_pc = '0; b64.out_ready = 1;
    rst_n = 1'b0;
    #12;
    checkOutput("reset.valid", 64'(b32.out_valid), 64'd0);
    checkOutput("reset.imm", 64'(b32.out_imm), 64'd0);
    checkOutput("reset.target", 64'(b32.out_target), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset.in_ready", 64'(b32.in_ready), 64'd1);

    // RV32 decode vectors
    runVector(0, "addi",   32'hFFF00093, 64'h0,        64'hFFFFFFFF, 3'd1, 6'd0,  1'b0, 64'h0);
    runVector(0, "beq",    32'hFE000EE3, 64'h100,      64'hFFFFFFFC, 3'd3, 6'd0,  1'b0, 64'hFC);
    runVector(0, "auipc",  32'h00001097, 64'h80000000, 64'h1000,     3'd4, 6'd0,  1'b0, 64'h80001000);
    runVector(0, "sw",     32'hFE112C23, 64'h40,       64'hFFFFFFF8, 3'd2, 6'd0,  1'b0, 64'h0);
    runVector(0, "jal",    32'h0080006F, 64'h200,      64'h8,        3'd5, 6'd0,  1'b0, 64'h208);
    runVector(0, "csrrwi", 32'h3002D073, 64'h44,       64'h5,        3'd7, 6'd0,  1'b0, 64'h0);
    runVector(0, "srai",   32'h40305093, 64'h48,       64'h3,        3'd6, 6'd3,  1'b0, 64'h0);
    runVector(0, "add",    32'h002081B3, 64'h4C,       64'h0,        3'd0, 6'd0,  1'b0, 64'h0);
    runVector(0, "bad_slli", 32'h40301093, 64'h50,     64'h0,        3'd0, 6'd0,  1'b1, 64'h0);
    runVector(0, "slli63_32", 32'h03F09093, 64'h54,    64'h0,        3'd0, 6'd0,  1'b1, 64'h0);
    runVector(0, "op7f_32", 32'h0000007F, 64'h58,      64'h0,        3'd0, 6'd0,  1'b1, 64'h0);
    runVector(0, "lowbits", 32'hFFF00090, 64'h5C,      64'h0,        3'd0, 6'd0,  1'b1, 64'h0);
    runVector(0, "addiw_32", 32'h0010009B, 64'h60,     64'h0,        3'd0, 6'd0,  1'b1, 64'h0);

    // RV64 decode vectors
    runVector(1, "slli63_64", 32'h03F09093, 64'h10,    64'd63,       3'd6, 6'd63, 1'b0, 64'h0);
    runVector(1, "op7f_64", 32'h0000007F, 64'h14,      64'h0,        3'd0, 6'd0,  1'b1, 64'h0);
    runVector(1, "addiw",  32'h0010009B, 64'h18,       64'h1,        3'd1, 6'd0,  1'b0, 64'h0);
    runVector(1, "slliw_bad", 32'h0210909B, 64'h1C,    64'h0,        3'd0, 6'd0,  1'b1, 64'h0);
    runVector(1, "beq64",  32'hFE000EE3, 64'h100,      64'hFFFFFFFFFFFFFFFC, 3'd3, 6'd0, 1'b0, 64'hFC);
    runVector(1, "lui64",  32'h800000B7, 64'h20,       64'hFFFFFFFF80000000, 3'd4, 6'd0, 1'b0, 64'h0);

    // Back-pressure: four lui with out_ready low for three cycles
    acc = 0;
    first_drop = -1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      b32.out_ready = (cyc >= 3);
      if (acc < 4) begin
        b32.in_valid = 1'b1;
        b32.in_inst  = 32'h123452B7;
        b32.in_pc    = 32'h400 + 32'(4 * acc);
      end else begin
        b32.in_valid = 1'b0;
      end
      if (!b32.in_ready && first_drop < 0) first_drop = acc;
      if (cyc == 2) checkOutput("bp.hold_pc", 64'(b32.out_pc), 64'h400);
      if (b32.out_valid && b32.out_ready) begin
        rx_pc.push_back(b32.out_pc);
        checkOutput("bp.imm", 64'(b32.out_imm), 64'h12345000);
      end
      if (b32.in_valid && b32.in_ready) acc++;
    end
    b32.in_valid = 1'b0;
    checkOutput("bp.drop_after", 64'(first_drop), 64'd2);
    checkOutput("bp.count", 64'(rx_pc.size()), 64'd4);
    for (int i = 0; i < rx_pc.size(); i++)
      checkOutput("bp.order", 64'(rx_pc[i]), 64'(32'h400 + 32'(4 * i)));

    // Flush with output and skid full plus an offered instruction
    @(negedge clk);
    b32.out_ready = 1'b0; b32.in_valid = 1'b1; b32.in_inst = 32'h123452B7; b32.in_pc = 32'hF00;
    @(negedge clk);
    b32.in_pc = 32'hF04;
    @(negedge clk);
    checkOutput("flush.full_ready", 64'(b32.in_ready), 64'd0);
    b32.in_pc = 32'hF08;
    b32.flush = 1'b1;
    @(negedge clk);
    b32.flush = 1'b0; b32.in_valid = 1'b0;
    checkOutput("flush.valid", 64'(b32.out_valid), 64'd0);
    checkOutput("flush.in_ready", 64'(b32.in_ready), 64'd1);
    b32.out_ready = 1'b1;
    countValid32(4, seen);
    checkOutput("flush.no_output", 64'(seen), 64'd0);

    // Flush while an input transfer would otherwise be accepted
    @(negedge clk);
    b32.out_ready = 1'b0; b32.in_valid = 1'b1; b32.in_pc = 32'hF10;
    @(negedge clk);
    b32.in_pc = 32'hF14;
    b32.flush = 1'b1;
    @(negedge clk);
    b32.flush = 1'b0; b32.in_valid = 1'b0;
    checkOutput("flush2.valid", 64'(b32.out_valid), 64'd0);
    checkOutput("flush2.in_ready", 64'(b32.in_ready), 64'd1);
    b32.out_ready = 1'b1;
    countValid32(4, seen);
    checkOutput("flush2.no_output", 64'(seen), 64'd0);

    // Asynchronous reset with output and skid full
    @(negedge clk);
    b32.out_ready = 1'b0; b32.in_valid = 1'b1; b32.in_inst = 32'hFFF00093; b32.in_pc = 32'h300;
    @(negedge clk);
    b32.in_pc = 32'h304;
    @(negedge clk);
    b32.in_valid = 1'b0;
    checkOutput("areset.pre_valid", 64'(b32.out_valid), 64'd1);
    checkOutput("areset.pre_ready", 64'(b32.in_ready), 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("areset.valid", 64'(b32.out_valid), 64'd0);
    checkOutput("areset.imm", 64'(b32.out_imm), 64'd0);
    checkOutput("areset.pc", 64'(b32.out_pc), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("areset.in_ready", 64'(b32.in_ready), 64'd1);
    checkOutput("areset.post_valid", 64'(b32.out_valid), 64'd0);
    b32.out_ready = 1'b1;

    // The pipe works normally after the reset
    runVector(0, "post_reset", 32'h123452B7, 64'h500, 64'h12345000, 3'd4, 6'd0, 1'b0, 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
